// File: rtl/sr_drv_pkg.sv
// Shared types and sizing helpers for the RS latch driver.
package sr_drv_pkg;

  typedef enum logic [2:0] {INIT, IDLE, PULSE, GAP, CHECK} sr_drv_state_t;

  // Down-counter width large enough to hold the longest phase length.
  function automatic int cnt_width(input int pulse_cyc, input int gap_cyc, input int timeout_cyc);
    int m;
    m = pulse_cyc;
    if (gap_cyc > m) m = gap_cyc;
    if (timeout_cyc > m) m = timeout_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, resets to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Clocked front-end driving S/R of an asynchronous RS latch with fixed-width
// pulses, idle gaps, and synchronized readback of the latch output.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_CYC   = 4,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic clr_req,
  output logic req_ready,
  output logic S,
  output logic R,
  input  logic q_fb,
  output logic q_exp,
  output logic done,
  output logic err
);

  localparam int CW = cnt_width(PULSE_CYC, GAP_CYC, TIMEOUT_CYC);
  typedef logic [CW-1:0] cnt_t;

  // The first post-reset edge is INIT's entry edge, so INIT starts one count higher.
  localparam cnt_t INIT_LOAD    = cnt_t'(PULSE_CYC);
  localparam cnt_t PULSE_LOAD   = cnt_t'(PULSE_CYC - 1);
  localparam cnt_t GAP_LOAD     = cnt_t'(GAP_CYC - 1);
  localparam cnt_t TIMEOUT_LOAD = cnt_t'(TIMEOUT_CYC - 1);

  sr_drv_state_t state_q, state_d;
  cnt_t          cnt_q, cnt_d;
  logic          q_exp_q, q_exp_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          s_q, r_q, ready_q;
  logic          q_sync;

  sync_2ff u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (q_fb),
    .q_o    (q_sync)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - cnt_t'(1) : '0;
    q_exp_d = q_exp_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      INIT: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (set_req && clr_req) begin
          err_d = 1'b1;
        end else if (set_req || clr_req) begin
          state_d = PULSE;
          cnt_d   = PULSE_LOAD;
          q_exp_d = set_req;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = CHECK;
          cnt_d   = TIMEOUT_LOAD;
        end
      end
      CHECK: begin
        if (q_sync == q_exp_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = INIT_LOAD;
      end
    endcase
  end

  // S/R are decoded from the next state so they are mutually exclusive flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= INIT_LOAD;
      q_exp_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_exp_q <= q_exp_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= (state_d == IDLE);
      s_q     <= (state_d == PULSE) && q_exp_d;
      r_q     <= (state_d == INIT) || ((state_d == PULSE) && !q_exp_d);
    end
  end

  assign req_ready = ready_q;
  assign S         = s_q;
  assign R         = r_q;
  assign q_exp     = q_exp_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver with a behavioural RS latch on S/R.
module tb_sr_latch_driver;

  localparam int PULSE_CYC   = 4;
  localparam int GAP_CYC     = 2;
  localparam int TIMEOUT_CYC = 16;
  localparam int LAT_DONE    = PULSE_CYC + GAP_CYC + 1;
  localparam int LAT_TMO     = PULSE_CYC + GAP_CYC + TIMEOUT_CYC;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_req = 1'b0;
  logic clr_req = 1'b0;
  logic req_ready, S, R, q_exp, done, err;
  logic q_latch = 1'b1;
  logic disconnect = 1'b0;
  logic q_fb;

  int checks = 0;
  int failures = 0;
  logic model_qexp = 1'b0;
  logic [2:0] exp_q[$];  // {done, err, q_exp}

  always #5 clk = ~clk;

  // RS latch: S and R are never high together, so the rising one decides Q.
  always @(posedge S or posedge R) q_latch = S;
  assign q_fb = disconnect ? 1'b0 : q_latch;

  sr_latch_driver #(
    .PULSE_CYC   (PULSE_CYC),
    .GAP_CYC     (GAP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_req   (set_req),
    .clr_req   (clr_req),
    .req_ready (req_ready),
    .S         (S),
    .R         (R),
    .q_fb      (q_fb),
    .q_exp     (q_exp),
    .done      (done),
    .err       (err)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every done/err pulse must match the oldest expected outcome.
  always @(negedge clk) begin
    check_eq("s_r_exclusive", {31'd0, S & R}, 32'd0);
    if (rst_n && (done || err)) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", {30'd0, done, err}, 32'd0);
      end else begin
        check_eq("sb_result", {29'd0, done, err, q_exp}, {29'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check_eq("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    int first_r, r_cnt, done_n;
    logic s_seen;
    rst_n = 1'b0;
    set_req = 1'b0;
    clr_req = 1'b0;
    exp_q.delete();
    model_qexp = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_outputs", {26'd0, S, R, done, err, req_ready, q_exp}, 32'd0);
    exp_q.push_back(3'b100);
    rst_n = 1'b1;
    first_r = -1;
    r_cnt = 0;
    done_n = -1;
    s_seen = 1'b0;
    for (int n = 1; n <= 40 && done_n < 0; n++) begin
      @(negedge clk);
      if (R && first_r < 0) first_r = n;
      if (R) r_cnt++;
      s_seen = s_seen | S;
      if (done) done_n = n;
    end
    check_eq("init_r_start", first_r, 32'd1);
    check_eq("init_r_width", r_cnt, PULSE_CYC);
    check_eq("init_no_s", {31'd0, s_seen}, 32'd0);
    check_eq("init_done_lat", done_n - first_r, LAT_DONE);
    check_eq("init_ready", {31'd0, req_ready}, 32'd1);
    check_eq("init_qexp", {31'd0, q_exp}, 32'd0);
    check_eq("init_latch_q", {31'd0, q_latch}, 32'd0);
  endtask

  // Issue one set (set_i=1) or clear command; lat = edges from accept to done/err.
  task automatic run_cmd(input logic set_i, input logic exp_done, input bit poke, output int lat);
    int pat_err;
    pat_err = 0;
    wait_ready();
    repeat ($urandom_range(0, 2)) @(negedge clk);
    model_qexp = set_i;
    exp_q.push_back({exp_done, ~exp_done, set_i});
    set_req = set_i;
    clr_req = ~set_i;
    lat = -1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      set_req = 1'b0;
      clr_req = 1'b0;
      if (n <= PULSE_CYC) begin
        if (S !== set_i || R !== ~set_i) pat_err++;
      end else if (S || R) begin
        pat_err++;
      end
      if (poke && n == 3) begin
        set_req = 1'b1;
        clr_req = 1'b1;
      end
      if (done || err) lat = n - 1;
    end
    set_req = 1'b0;
    clr_req = 1'b0;
    check_eq("pulse_pattern", pat_err, 32'd0);
    check_eq("cmd_qexp", {31'd0, q_exp}, {31'd0, model_qexp});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic q_before;
    logic rnd;

    // 1. reset release and INIT sequence
    do_reset();

    // 2. single set
    run_cmd(1'b1, 1'b1, 1'b0, lat);
    check_eq("set_latency", lat, LAT_DONE);
    check_eq("set_latch_q", {31'd0, q_latch}, 32'd1);

    // 3. simultaneous set and clear
    wait_ready();
    q_before = q_latch;
    exp_q.push_back({2'b01, model_qexp});
    set_req = 1'b1;
    clr_req = 1'b1;
    @(negedge clk);
    set_req = 1'b0;
    clr_req = 1'b0;
    check_eq("illegal_err", {31'd0, err}, 32'd1);
    check_eq("illegal_ready", {31'd0, req_ready}, 32'd1);
    check_eq("illegal_sr", {30'd0, S, R}, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("illegal_idle_sr", {29'd0, S, R, req_ready}, 32'd1);
    check_eq("illegal_latch_q", {31'd0, q_latch}, {31'd0, q_before});
    check_eq("illegal_qexp", {31'd0, q_exp}, {31'd0, model_qexp});

    // 4. latch disconnected: readback never matches
    run_cmd(1'b0, 1'b1, 1'b0, lat);
    check_eq("clr_latency", lat, LAT_DONE);
    disconnect = 1'b1;
    run_cmd(1'b1, 1'b0, 1'b0, lat);
    check_eq("timeout_latency", lat, LAT_TMO);
    check_eq("timeout_ready", {31'd0, req_ready}, 32'd1);
    disconnect = 1'b0;

    // 5. reset asserted mid-pulse
    run_cmd(1'b0, 1'b1, 1'b0, lat);
    wait_ready();
    set_req = 1'b1;
    @(negedge clk);
    set_req = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midpulse_s_high", {30'd0, S, R}, 32'd2);
    rst_n = 1'b0;
    #1;
    check_eq("midpulse_async_drop", {30'd0, S, R}, 32'd0);
    do_reset();

    // 6. back-to-back set/clr/set/set/clr, with a busy-time request on one
    run_cmd(1'b1, 1'b1, 1'b0, lat);
    check_eq("seq0_latency", lat, LAT_DONE);
    run_cmd(1'b0, 1'b1, 1'b1, lat);
    check_eq("seq1_latency", lat, LAT_DONE);
    check_eq("seq1_latch_q", {31'd0, q_latch}, 32'd0);
    run_cmd(1'b1, 1'b1, 1'b0, lat);
    check_eq("seq2_latency", lat, LAT_DONE);
    run_cmd(1'b1, 1'b1, 1'b0, lat);
    check_eq("seq3_repeat_latency", lat, LAT_DONE);
    check_eq("seq3_latch_q", {31'd0, q_latch}, 32'd1);
    run_cmd(1'b0, 1'b1, 1'b0, lat);
    check_eq("seq4_latency", lat, LAT_DONE);
    check_eq("seq4_latch_q", {31'd0, q_latch}, 32'd0);

    // random command mix
    for (int i = 0; i < 6; i++) begin
      rnd = 1'($urandom_range(0, 1));
      run_cmd(rnd, 1'b1, 1'($urandom_range(0, 1)), lat);
      check_eq("rnd_latency", lat, LAT_DONE);
      check_eq("rnd_latch_q", {31'd0, q_latch}, {31'd0, rnd});
    end

    repeat (4) @(negedge clk);
    check_eq("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
